// File: rtl/plaintext_report.sv
// Rebuilds a winning Skein plaintext and streams it as a framed byte sequence.
// Latency: first byte valid 1 cycle after found_i; back-to-back bytes; stalls hold tx_data_o.
module plaintext_report (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         found_i,
  input  logic [255:0] nonce_i,
  input  logic [31:0]  core_i,
  input  logic [10:0]  score_i,
  output logic [7:0]   tx_data_o,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  output logic         busy_o,
  output logic [15:0]  dropped_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] HEADER   = 3'd1;
  localparam logic [2:0] PAYLOAD  = 3'd2;
  localparam logic [2:0] SCORE_HI = 3'd3;
  localparam logic [2:0] SCORE_LO = 3'd4;
  localparam logic [2:0] TERM     = 3'd5;

  localparam logic [215:0] SUFFIX = 216'h5F6D6F_632e6c69616d6740_6d61686b72694b2e_412e6c65696e6144;

  logic [2:0]   state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [255:0] act_nonce_q, act_nonce_d;
  logic [31:0]  act_core_q, act_core_d;
  logic [10:0]  act_score_q, act_score_d;
  logic         pnd_vld_q, pnd_vld_d;
  logic [255:0] pnd_nonce_q, pnd_nonce_d;
  logic [31:0]  pnd_core_q, pnd_core_d;
  logic [10:0]  pnd_score_q, pnd_score_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         tx_valid_q, tx_valid_d;
  logic         busy_q, busy_d;
  logic [15:0]  drop_q, drop_d;
  logic         accept;
  logic         cap_act;
  logic         drop_inc;
  logic [511:0] plain_d;

  assign accept = tx_valid_q && tx_ready_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_nonce_d = act_nonce_q;
    act_core_d  = act_core_q;
    act_score_d = act_score_q;
    pnd_vld_d   = pnd_vld_q;
    pnd_nonce_d = pnd_nonce_q;
    pnd_core_d  = pnd_core_q;
    pnd_score_d = pnd_score_q;
    drop_d      = drop_q;
    cap_act     = 1'b0;
    drop_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (found_i) begin
          cap_act = 1'b1;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (accept) begin
          state_d = PAYLOAD;
          cnt_d   = 6'd0;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_d = SCORE_HI;
        end
      end
      SCORE_HI: if (accept) state_d = SCORE_LO;
      SCORE_LO: if (accept) state_d = TERM;
      TERM: begin
        if (accept) begin
          if (pnd_vld_q) begin
            act_nonce_d = pnd_nonce_q;
            act_core_d  = pnd_core_q;
            act_score_d = pnd_score_q;
            pnd_vld_d   = 1'b0;
            state_d     = HEADER;
          end else if (found_i) begin
            cap_act = 1'b1;
            state_d = HEADER;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (cap_act) begin
      act_nonce_d = nonce_i;
      act_core_d  = core_i;
      act_score_d = score_i;
    end else if (found_i) begin
      // Sees the slot after any promotion this cycle, so a freshly emptied slot accepts the new result.
      if (!pnd_vld_d) begin
        pnd_vld_d   = 1'b1;
        pnd_nonce_d = nonce_i;
        pnd_core_d  = core_i;
        pnd_score_d = score_i;
      end else if (score_i < pnd_score_d) begin
        pnd_nonce_d = nonce_i;
        pnd_core_d  = core_i;
        pnd_score_d = score_i;
        drop_inc    = 1'b1;
      end else begin
        drop_inc    = 1'b1;
      end
    end

    if (drop_inc && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  assign plain_d = {act_nonce_d, 8'h5F, act_core_d, SUFFIX};

  // Output byte is registered from next-state so it lines up with the state that presents it.
  always_comb begin
    tx_data_d = 8'h00;
    case (state_d)
      HEADER:   tx_data_d = 8'h02;
      PAYLOAD:  tx_data_d = plain_d[{cnt_d, 3'b000} +: 8];
      SCORE_HI: tx_data_d = {5'b00000, act_score_d[10:8]};
      SCORE_LO: tx_data_d = act_score_d[7:0];
      TERM:     tx_data_d = 8'h0A;
      default:  tx_data_d = 8'h00;
    endcase
    tx_valid_d = (state_d != IDLE);
    busy_d     = (state_d != IDLE) || pnd_vld_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      act_nonce_q <= '0;
      act_core_q  <= '0;
      act_score_q <= '0;
      pnd_vld_q   <= 1'b0;
      pnd_nonce_q <= '0;
      pnd_core_q  <= '0;
      pnd_score_q <= '0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_nonce_q <= act_nonce_d;
      act_core_q  <= act_core_d;
      act_score_q <= act_score_d;
      pnd_vld_q   <= pnd_vld_d;
      pnd_nonce_q <= pnd_nonce_d;
      pnd_core_q  <= pnd_core_d;
      pnd_score_q <= pnd_score_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign dropped_o  = drop_q;

endmodule

// File: tb/tb_plaintext_report.sv
// Directed bench for plaintext_report: frame contents, stalls, pending slot, drops, reset abort.
module tb_plaintext_report;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         found_i = 1'b0;
  logic [255:0] nonce_i = '0;
  logic [31:0]  core_i = '0;
  logic [10:0]  score_i = '0;
  logic [7:0]   tx_data_o;
  logic         tx_valid_o;
  logic         tx_ready_i = 1'b0;
  logic         busy_o;
  logic [15:0]  dropped_o;

  int passed = 0;
  int total  = 0;
  int last_cycles = 0;
  logic [7:0] exp_q[$];

  localparam logic [7:0] EMAIL [27] = '{
    8'h44, 8'h61, 8'h6E, 8'h69, 8'h65, 8'h6C, 8'h2E, 8'h41, 8'h2E, 8'h4B, 8'h69, 8'h72, 8'h6B, 8'h68,
    8'h61, 8'h6D, 8'h40, 8'h67, 8'h6D, 8'h61, 8'h69, 8'h6C, 8'h2E, 8'h63, 8'h6F, 8'h6D, 8'h5F};

  plaintext_report dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .found_i(found_i), .nonce_i(nonce_i), .core_i(core_i),
    .score_i(score_i), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .dropped_o(dropped_o));

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_frame(input logic [255:0] n, input logic [31:0] c, input logic [10:0] s);
    exp_q.push_back(8'h02);
    for (int k = 0; k < 27; k++) exp_q.push_back(EMAIL[k]);
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    exp_q.push_back(8'h5F);
    for (int k = 0; k < 32; k++) exp_q.push_back(n[8*k +: 8]);
    exp_q.push_back({5'b00000, s[10:8]});
    exp_q.push_back(s[7:0]);
    exp_q.push_back(8'h0A);
  endtask

  // Drives one found_i strobe; with rdy set, the byte on the wire that cycle is accepted and checked.
  task automatic pulse(input logic [255:0] n, input logic [31:0] c, input logic [10:0] s, input bit rdy);
    found_i = 1'b1; nonce_i = n; core_i = c; score_i = s; tx_ready_i = rdy;
    if (rdy && tx_valid_o) check("pulse_byte", {24'h0, tx_data_o}, {24'h0, exp_q.pop_front()});
    step();
    found_i = 1'b0; tx_ready_i = 1'b0;
  endtask

  task automatic collect(input int n, input bit rnd);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [7:0] held = 8'h00;
    while (got < n && cyc < 2000) begin
      tx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid_o) begin
        if (stalled) check("hold", {24'h0, tx_data_o}, {24'h0, held});
        if (tx_ready_i) begin
          check("byte", {24'h0, tx_data_o}, {24'h0, exp_q.pop_front()});
          got++;
          stalled = 1'b0;
        end else begin
          held = tx_data_o;
          stalled = 1'b1;
        end
      end else begin
        stalled = 1'b0;
      end
      step();
      cyc++;
    end
    if (got < n) check("timeout", got, n);
    tx_ready_i = 1'b0;
    last_cycles = cyc;
  endtask

  initial begin
    #2;
    check("rst_valid", {31'h0, tx_valid_o}, 0);
    check("rst_data", {24'h0, tx_data_o}, 0);
    check("rst_busy", {31'h0, busy_o}, 0);
    check("rst_drop", {16'h0, dropped_o}, 0);
    step();
    rst_n_i = 1'b1;
    step(); step();

    // Test-plan frame: nonce 0, core 3, score 402
    push_frame('0, 32'h3, 11'd402);
    pulse('0, 32'h3, 11'd402, 1'b0);
    check("lat_valid", {31'h0, tx_valid_o}, 1);
    check("lat_data", {24'h0, tx_data_o}, 32'h02);
    collect(68, 1'b0);
    check("a_cycles", last_cycles, 68);
    check("a_idle", {31'h0, tx_valid_o}, 0);
    check("a_busy", {31'h0, busy_o}, 0);

    // Same frame under random backpressure
    push_frame('0, 32'h3, 11'd402);
    pulse('0, 32'h3, 11'd402, 1'b0);
    collect(68, 1'b1);
    step();
    check("b_idle", {31'h0, tx_valid_o}, 0);

    // Pending promotion: no gap between frames
    push_frame({8{32'h1122_3344}}, 32'h5, 11'd100);
    push_frame({8{32'hDEAD_BEEF}}, 32'h7, 11'd300);
    pulse({8{32'h1122_3344}}, 32'h5, 11'd100, 1'b0);
    collect(10, 1'b0);
    pulse({8{32'hDEAD_BEEF}}, 32'h7, 11'd300, 1'b1);
    collect(124, 1'b0);
    check("c_cycles", last_cycles, 124);
    check("c_busy_last", {31'h0, busy_o}, 1);
    check("c_last_byte", {24'h0, tx_data_o}, 32'h0A);
    collect(1, 1'b0);
    check("c_busy_done", {31'h0, busy_o}, 0);
    check("c_idle", {31'h0, tx_valid_o}, 0);
    check("c_drop", {16'h0, dropped_o}, 0);

    // Three arrivals in one frame: lowest score kept, two dropped
    push_frame({4{64'h0F0E_0D0C_0B0A_0908}}, 32'h11, 11'd1024);
    push_frame({8{32'h2222_2222}}, 32'h22, 11'd200);
    pulse({4{64'h0F0E_0D0C_0B0A_0908}}, 32'h11, 11'd1024, 1'b0);
    collect(5, 1'b0);
    pulse({8{32'h1111_1111}}, 32'h21, 11'd500, 1'b0);
    check("d_busy", {31'h0, busy_o}, 1);
    pulse({8{32'h2222_2222}}, 32'h22, 11'd200, 1'b0);
    pulse({8{32'h3333_3333}}, 32'h23, 11'd600, 1'b0);
    check("d_drop", {16'h0, dropped_o}, 2);
    collect(131, 1'b0);
    step();
    check("d_idle", {31'h0, tx_valid_o}, 0);

    // Arrival on the final accept with nothing pending goes straight to active
    push_frame({8{32'hCAFE_F00D}}, 32'h8, 11'd5);
    push_frame({8{32'h0BAD_CAFE}}, 32'h9, 11'd77);
    pulse({8{32'hCAFE_F00D}}, 32'h8, 11'd5, 1'b0);
    collect(67, 1'b0);
    pulse({8{32'h0BAD_CAFE}}, 32'h9, 11'd77, 1'b1);
    check("e_valid", {31'h0, tx_valid_o}, 1);
    check("e_hdr", {24'h0, tx_data_o}, 32'h02);
    collect(68, 1'b0);
    check("e_drop", {16'h0, dropped_o}, 2);
    check("e_busy", {31'h0, busy_o}, 0);

    // Reset mid-payload with a pending result
    push_frame({8{32'h5555_AAAA}}, 32'h1, 11'd9);
    pulse({8{32'h5555_AAAA}}, 32'h1, 11'd9, 1'b0);
    collect(21, 1'b0);
    pulse({8{32'h7777_7777}}, 32'h2, 11'd3, 1'b0);
    check("f_busy_pre", {31'h0, busy_o}, 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("f_valid", {31'h0, tx_valid_o}, 0);
    check("f_busy", {31'h0, busy_o}, 0);
    check("f_drop", {16'h0, dropped_o}, 0);
    check("f_data", {24'h0, tx_data_o}, 0);
    exp_q.delete();
    step();
    rst_n_i = 1'b1;
    tx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("f_quiet_valid", {31'h0, tx_valid_o}, 0);
    check("f_quiet_busy", {31'h0, busy_o}, 0);
    tx_ready_i = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
